// File: rtl/wb_pkg.sv
// Shared Wishbone initiator types: FSM states, response codes and the PWM timer
// address map used by both this master and the bus-splitter decode.
package wb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUS  = 2'd1,
        RESP = 2'd2
    } wb_state_e;

    localparam int unsigned RSP_CODE_W = 2;

    localparam logic [RSP_CODE_W-1:0] RSP_OK  = 2'd0;
    localparam logic [RSP_CODE_W-1:0] RSP_ERR = 2'd1;
    localparam logic [RSP_CODE_W-1:0] RSP_TMO = 2'd2;

    // EF_TMR32_WB PWM timer instances, one 64 KiB window each
    localparam logic [31:0] PWM0_BASE   = 32'h3000_0000;
    localparam logic [31:0] PWM1_BASE   = 32'h3001_0000;
    localparam logic [31:0] PWM2_BASE   = 32'h3002_0000;
    localparam logic [31:0] PWM3_BASE   = 32'h3003_0000;
    localparam logic [31:0] PWM_WIN_MSK = 32'hFFFF_0000;

    function automatic logic is_pwm_adr(input logic [31:0] adr);
        logic [31:0] w_win;
        w_win = adr & PWM_WIN_MSK;
        return (w_win == PWM0_BASE) || (w_win == PWM1_BASE) ||
               (w_win == PWM2_BASE) || (w_win == PWM3_BASE);
    endfunction

endpackage

// File: rtl/wb_init_watchdog.sv
// Bus-cycle watchdog: counts cycles while enabled and flags the last allowed
// cycle. Disabled entirely (expire stuck low) when TIMEOUT is 0.
module wb_init_watchdog #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_clr,
    input  logic i_en,
    output logic o_expire_c
);

    generate
        if (TIMEOUT == 0) begin : g_off
            logic w_unused;
            assign w_unused   = ^{clk, rst_n, i_clr, i_en};
            assign o_expire_c = 1'b0;
        end else begin : g_on
            localparam int unsigned TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
            localparam logic [TW-1:0] LAST = TW'(TIMEOUT - 1);

            logic [TW-1:0] r_cnt;

            // Holds at LAST so the count can never wrap back into range
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_cnt <= '0;
                end else if (i_clr) begin
                    r_cnt <= '0;
                end else if (i_en && (r_cnt != LAST)) begin
                    r_cnt <= r_cnt + TW'(1);
                end
            end

            assign o_expire_c = i_en && (r_cnt == LAST);
        end
    endgenerate

endmodule

// File: rtl/wb_master_initiator.sv
// Single-outstanding Wishbone classic master: valid/ready request in, one bus
// cycle with watchdog, valid/ready response out, saturating error counter.
module wb_master_initiator
    import wb_pkg::*;
#(
    parameter int unsigned AW      = 32,
    parameter int unsigned DW      = 32,
    parameter int unsigned TIMEOUT = 255,
    parameter int unsigned ECW     = 8
) (
    input  logic            wb_clk_i,
    input  logic            wb_rst_ni,

    input  logic            req_valid_i,
    output logic            req_ready_o,
    input  logic            req_we_i,
    input  logic [AW-1:0]   req_adr_i,
    input  logic [DW-1:0]   req_dat_i,
    input  logic [DW/8-1:0] req_sel_i,

    output logic            rsp_valid_o,
    input  logic            rsp_ready_i,
    output logic [DW-1:0]   rsp_dat_o,
    output logic            rsp_err_o,
    output logic            rsp_timeout_o,

    output logic            m_wb_cyc_o,
    output logic            m_wb_stb_o,
    output logic            m_wb_we_o,
    output logic [AW-1:0]   m_wb_adr_o,
    output logic [DW-1:0]   m_wb_dat_o,
    output logic [DW/8-1:0] m_wb_sel_o,
    input  logic [DW-1:0]   m_wb_dat_i,
    input  logic            m_wb_ack_i,
    input  logic            m_wb_err_i,

    output logic            busy_o,
    output logic [ECW-1:0]  err_cnt_o
);

    localparam int unsigned SW = DW / 8;

    wb_state_e             r_state;
    logic                  r_cyc;
    logic                  r_stb;
    logic                  r_we;
    logic [AW-1:0]         r_adr;
    logic [DW-1:0]         r_dat;
    logic [SW-1:0]         r_sel;
    logic                  r_rsp_valid;
    logic [DW-1:0]         r_rsp_dat;
    logic                  r_rsp_err;
    logic                  r_rsp_timeout;
    logic [ECW-1:0]        r_err_cnt;

    logic                  w_expire;
    logic                  w_term;
    logic [RSP_CODE_W-1:0] w_code;

    wb_init_watchdog #(
        .TIMEOUT    (TIMEOUT)
    ) u_watchdog (
        .clk        (wb_clk_i),
        .rst_n      (wb_rst_ni),
        .i_clr      (r_state != BUS),
        .i_en       (r_state == BUS),
        .o_expire_c (w_expire)
    );

    // Termination priority: err beats ack, ack beats the watchdog
    always_comb begin
        w_code = RSP_OK;
        if (m_wb_err_i) begin
            w_code = RSP_ERR;
        end else if (m_wb_ack_i) begin
            w_code = RSP_OK;
        end else if (w_expire) begin
            w_code = RSP_TMO;
        end
    end

    assign w_term = m_wb_ack_i || m_wb_err_i || w_expire;

    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            r_state       <= IDLE;
            r_cyc         <= 1'b0;
            r_stb         <= 1'b0;
            r_we          <= 1'b0;
            r_adr         <= '0;
            r_dat         <= '0;
            r_sel         <= '0;
            r_rsp_valid   <= 1'b0;
            r_rsp_dat     <= '0;
            r_rsp_err     <= 1'b0;
            r_rsp_timeout <= 1'b0;
            r_err_cnt     <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (req_valid_i) begin
                        r_cyc   <= 1'b1;
                        r_stb   <= 1'b1;
                        r_we    <= req_we_i;
                        r_adr   <= req_adr_i;
                        r_dat   <= req_we_i ? req_dat_i : '0;
                        r_sel   <= req_sel_i;
                        r_state <= BUS;
                    end
                end
                BUS: begin
                    if (w_term) begin
                        r_cyc         <= 1'b0;
                        r_stb         <= 1'b0;
                        r_we          <= 1'b0;
                        r_adr         <= '0;
                        r_dat         <= '0;
                        r_sel         <= '0;
                        r_rsp_valid   <= 1'b1;
                        r_rsp_err     <= (w_code != RSP_OK);
                        r_rsp_timeout <= (w_code == RSP_TMO);
                        r_rsp_dat     <= ((w_code == RSP_OK) && !r_we) ? m_wb_dat_i : '0;
                        if ((w_code != RSP_OK) && (r_err_cnt != '1)) begin
                            r_err_cnt <= r_err_cnt + ECW'(1);
                        end
                        r_state       <= RESP;
                    end
                end
                RESP: begin
                    if (rsp_ready_i) begin
                        r_rsp_valid   <= 1'b0;
                        r_rsp_dat     <= '0;
                        r_rsp_err     <= 1'b0;
                        r_rsp_timeout <= 1'b0;
                        r_state       <= IDLE;
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign req_ready_o   = (r_state == IDLE);
    assign busy_o        = (r_state != IDLE);

    assign m_wb_cyc_o    = r_cyc;
    assign m_wb_stb_o    = r_stb;
    assign m_wb_we_o     = r_we;
    assign m_wb_adr_o    = r_adr;
    assign m_wb_dat_o    = r_dat;
    assign m_wb_sel_o    = r_sel;

    assign rsp_valid_o   = r_rsp_valid;
    assign rsp_dat_o     = r_rsp_dat;
    assign rsp_err_o     = r_rsp_err;
    assign rsp_timeout_o = r_rsp_timeout;
    assign err_cnt_o     = r_err_cnt;

endmodule

// File: tb/tb_wb_master_initiator.sv
// Directed bench for wb_master_initiator: a vector table of single transactions
// against a bench-driven slave, plus hand sequences for stall, saturation and reset.
module tb_wb_master_initiator;

    logic        clk;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [31:0] req_adr;
    logic [31:0] req_dat;
    logic [3:0]  req_sel;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_dat;
    logic        rsp_err;
    logic        rsp_timeout;
    logic        m_cyc;
    logic        m_stb;
    logic        m_we;
    logic [31:0] m_adr;
    logic [31:0] m_dat_o;
    logic [3:0]  m_sel;
    logic [31:0] s_dat;
    logic        s_ack;
    logic        s_err;
    logic        busy;
    logic [7:0]  err_cnt;

    int n_vec  = 0;
    int n_miss = 0;
    int exp_cnt = 0;

    wb_master_initiator #(
        .AW(32), .DW(32), .TIMEOUT(8), .ECW(8)
    ) dut (
        .wb_clk_i      (clk),
        .wb_rst_ni     (rst_n),
        .req_valid_i   (req_valid),
        .req_ready_o   (req_ready),
        .req_we_i      (req_we),
        .req_adr_i     (req_adr),
        .req_dat_i     (req_dat),
        .req_sel_i     (req_sel),
        .rsp_valid_o   (rsp_valid),
        .rsp_ready_i   (rsp_ready),
        .rsp_dat_o     (rsp_dat),
        .rsp_err_o     (rsp_err),
        .rsp_timeout_o (rsp_timeout),
        .m_wb_cyc_o    (m_cyc),
        .m_wb_stb_o    (m_stb),
        .m_wb_we_o     (m_we),
        .m_wb_adr_o    (m_adr),
        .m_wb_dat_o    (m_dat_o),
        .m_wb_sel_o    (m_sel),
        .m_wb_dat_i    (s_dat),
        .m_wb_ack_i    (s_ack),
        .m_wb_err_i    (s_err),
        .busy_o        (busy),
        .err_cnt_o     (err_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        we;
        logic [31:0] adr;
        logic [31:0] dat;
        logic [3:0]  sel;
        int          delay;     // BUS cycle index (0-based) in which the slave terminates
        logic        ack;
        logic        err;
        logic [31:0] rdata;
        int          exp_cyc;   // cycles with cyc high
        logic        exp_err;
        logic        exp_tmo;
        logic [31:0] exp_dat;
        logic        late_ack;
    } vec_t;

    vec_t tbl[7];

    function automatic vec_t mk(input logic we, input logic [31:0] adr, input logic [31:0] dat,
                                input logic [3:0] sel, input int delay, input logic ack,
                                input logic err, input logic [31:0] rdata, input int exp_cyc,
                                input logic exp_err, input logic exp_tmo,
                                input logic [31:0] exp_dat, input logic late_ack);
        vec_t v;
        v.we = we; v.adr = adr; v.dat = dat; v.sel = sel; v.delay = delay;
        v.ack = ack; v.err = err; v.rdata = rdata; v.exp_cyc = exp_cyc;
        v.exp_err = exp_err; v.exp_tmo = exp_tmo; v.exp_dat = exp_dat; v.late_ack = late_ack;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    // One complete transaction: request, slave reply, response checks, handshake.
    task automatic run_vec(input vec_t v);
        int   cyc_n;
        int   lat;
        bit   got;
        bit   bus_bad;
        @(negedge clk);
        req_we = v.we; req_adr = v.adr; req_dat = v.dat; req_sel = v.sel; req_valid = 1'b1;
        check("req_ready_idle", 32'(req_ready), 32'd1);
        @(negedge clk);
        req_valid = 1'b0;
        lat = 1; cyc_n = 0; got = 1'b0; bus_bad = 1'b0;
        for (int k = 0; k < 40 && !got; k++) begin
            if (m_cyc) begin
                cyc_n++;
                if (!m_stb || m_adr !== v.adr || m_we !== v.we || m_sel !== v.sel ||
                    m_dat_o !== (v.we ? v.dat : 32'h0) || req_ready !== 1'b0)
                    bus_bad = 1'b1;
                if (cyc_n - 1 == v.delay) begin
                    s_ack = v.ack; s_err = v.err; s_dat = v.rdata;
                end
            end
            if (rsp_valid) begin
                got = 1'b1;
            end else begin
                @(negedge clk);
                s_ack = 1'b0; s_err = 1'b0; s_dat = 32'h0;
                lat++;
            end
        end
        s_ack = 1'b0; s_err = 1'b0; s_dat = 32'h0;
        if (v.exp_err && exp_cnt < 255) exp_cnt++;
        check("rsp_valid_seen", 32'(got), 32'd1);
        check("bus_stable", 32'(bus_bad), 32'd0);
        check("cyc_cycles", 32'(cyc_n), 32'(v.exp_cyc));
        check("rsp_latency", 32'(lat), 32'(v.exp_cyc + 1));
        check("rsp_err", 32'(rsp_err), 32'(v.exp_err));
        check("rsp_timeout", 32'(rsp_timeout), 32'(v.exp_tmo));
        check("rsp_dat", rsp_dat, v.exp_dat);
        check("err_cnt", 32'(err_cnt), 32'(exp_cnt));
        if (v.late_ack) begin
            @(negedge clk);
            s_ack = 1'b1; s_dat = 32'h1111_2222;
            @(negedge clk);
            s_ack = 1'b0; s_dat = 32'h0;
            check("late_ack_rsp_hold", {29'd0, rsp_valid, rsp_err, rsp_timeout}, 32'd7);
            check("late_ack_dat_hold", rsp_dat, 32'h0);
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        check("rsp_valid_drop", 32'(rsp_valid), 32'd0);
        check("back_to_idle", {30'd0, req_ready, busy}, 32'd2);
        if (v.late_ack) begin
            bus_bad = 1'b0;
            for (int k = 0; k < 3; k++) begin
                @(negedge clk);
                if (rsp_valid || m_cyc) bus_bad = 1'b1;
            end
            check("late_ack_no_second_rsp", 32'(bus_bad), 32'd0);
        end
    endtask

    initial begin
        rst_n = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_adr = '0; req_dat = '0;
        req_sel = '0; rsp_ready = 1'b0; s_ack = 1'b0; s_err = 1'b0; s_dat = '0;

        tbl[0] = mk(1'b1, 32'h3001_0004, 32'h0000_1234, 4'hF, 0,  1'b1, 1'b0, 32'h0,         1, 1'b0, 1'b0, 32'h0,         1'b0);
        tbl[1] = mk(1'b0, 32'h3002_0000, 32'h0,         4'hF, 3,  1'b1, 1'b0, 32'hDEAD_BEEF, 4, 1'b0, 1'b0, 32'hDEAD_BEEF, 1'b0);
        tbl[2] = mk(1'b0, 32'h3000_0008, 32'h0,         4'hF, 99, 1'b0, 1'b0, 32'h0,         8, 1'b1, 1'b1, 32'h0,         1'b1);
        tbl[3] = mk(1'b1, 32'h3003_0000, 32'h0000_00FF, 4'hF, 0,  1'b1, 1'b1, 32'h0,         1, 1'b1, 1'b0, 32'h0,         1'b0);
        tbl[4] = mk(1'b0, 32'h3000_0010, 32'h0,         4'hF, 1,  1'b0, 1'b1, 32'h0000_0055, 2, 1'b1, 1'b0, 32'h0,         1'b0);
        tbl[5] = mk(1'b0, 32'h3001_0020, 32'h0,         4'h3, 7,  1'b1, 1'b0, 32'h0000_CAFE, 8, 1'b0, 1'b0, 32'h0000_CAFE, 1'b0);
        tbl[6] = mk(1'b1, 32'h3002_0100, 32'hA5A5_5A5A, 4'h1, 2,  1'b1, 1'b0, 32'h7777_7777, 3, 1'b0, 1'b0, 32'h0,         1'b0);

        #1;
        check("reset_outputs", {24'd0, m_cyc, m_stb, m_we, rsp_valid, rsp_err, rsp_timeout, busy, req_ready}, 32'd1);
        check("reset_bus_vals", m_adr | m_dat_o | {28'd0, m_sel} | rsp_dat | {24'd0, err_cnt}, 32'h0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 7; i++) run_vec(tbl[i]);

        // Response back-pressure with a new request waiting
        @(negedge clk);
        req_we = 1'b1; req_adr = 32'h3000_0000; req_dat = 32'h0000_00A5; req_sel = 4'hF; req_valid = 1'b1;
        @(negedge clk);
        req_we = 1'b0; req_adr = 32'h3002_0004; req_dat = 32'h0; req_sel = 4'hC;
        check("stall_cyc_first", {31'd0, m_cyc}, 32'd1);
        check("stall_adr_first", m_adr, 32'h3000_0000);
        s_ack = 1'b1;
        @(negedge clk);
        s_ack = 1'b0;
        for (int k = 0; k < 5; k++) begin
            check("stall_hold", {28'd0, req_ready, m_cyc, rsp_valid, rsp_err}, 32'd2);
            check("stall_rsp_dat", rsp_dat, 32'h0);
            @(negedge clk);
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        check("stall_release", {30'd0, req_ready, rsp_valid}, 32'd2);
        @(negedge clk);
        req_valid = 1'b0;
        check("stall_next_cyc", {30'd0, m_cyc, m_we}, 32'd2);
        check("stall_next_adr", m_adr, 32'h3002_0004);
        s_ack = 1'b1; s_dat = 32'h0BAD_F00D;
        @(negedge clk);
        s_ack = 1'b0; s_dat = 32'h0;
        check("stall_next_rsp", rsp_dat, 32'h0BAD_F00D);
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;

        // Saturating error counter
        for (int i = 0; i < 300; i++) run_vec(tbl[3]);
        check("err_cnt_saturated", 32'(err_cnt), 32'd255);

        // Asynchronous reset in the second BUS cycle
        @(negedge clk);
        req_we = 1'b0; req_adr = 32'h3001_0000; req_sel = 4'hF; req_valid = 1'b1;
        @(negedge clk);
        req_valid = 1'b0;
        @(negedge clk);
        check("rst_pre_cyc", {31'd0, m_cyc}, 32'd1);
        rst_n = 1'b0;
        #1;
        check("rst_async_drop", {28'd0, m_cyc, m_stb, rsp_valid, busy}, 32'd0);
        check("rst_async_state", {24'd0, err_cnt}, 32'd0);
        check("rst_async_ready", {31'd0, req_ready}, 32'd1);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("rst_after", {24'd0, err_cnt} | {30'd0, m_cyc, rsp_valid}, 32'd0);
        check("rst_after_ready", {31'd0, req_ready}, 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
